// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared encodings and defaults for the PC redirect unit
package pc_redirect_unit_pkg;
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
    typedef enum logic {JMP = 1'b0, BR = 1'b1} ptype_t;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int DEF_INC = 4;
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: redirect inputs and PC/status outputs of the PC stage
interface pc_redirect_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_inc;
    logic             flush;
    logic             pending;
    logic             misalign_err;
    logic [CNT_W-1:0] redirect_count;
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
        input  pc, pc_plus_inc, flush, pending, misalign_err, redirect_count
    );
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
        output pc, pc_plus_inc, flush, pending, misalign_err, redirect_count
    );
endinterface

// File: rtl/pc_redirect_unit_redirect_latch.sv
// pc_redirect_unit_redirect_latch: holds a redirect that arrived during a stall
module pc_redirect_unit_redirect_latch
    import pc_redirect_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             hold,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pend_target,
    output logic             jump_acc
);
    ptype_t pend_type;
    // a jump is taken only when no branch competes, and never over a pending branch
    assign jump_acc = jump & ~branch_taken & (~hold | (stall & pend_type == JMP));
    // capture or overwrite the pending target; releasing the stall empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_target <= '0;
            pend_type   <= JMP;
        end else if (hold && !stall) begin
            pend_target <= '0;
            pend_type   <= JMP;
        end else if (stall && branch_taken) begin
            pend_target <= {branch_target[WIDTH-1:2], 2'b00};
            pend_type   <= BR;
        end else if (stall && jump_acc) begin
            pend_target <= {jump_target[WIDTH-1:2], 2'b00};
            pend_type   <= JMP;
        end
    end
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: PC register with branch/jump redirect, stall latching and IF/ID flush
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter int               INC      = DEF_INC,
    parameter int               CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    pc_redirect_unit_if.slave bus
);
    state_t           st, st_nxt;
    logic             hold, apply, mis, jump_acc;
    logic [WIDTH-1:0] pc_q, pend_target, raw_tgt;
    logic             flush_q, err_q;
    logic [CNT_W-1:0] cnt_q;
    pc_redirect_unit_redirect_latch #(.WIDTH(WIDTH)) u_latch (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (bus.stall),
        .hold         (hold),
        .branch_taken (bus.branch_taken),
        .branch_target(bus.branch_target),
        .jump         (bus.jump),
        .jump_target  (bus.jump_target),
        .pend_target  (pend_target),
        .jump_acc     (jump_acc)
    );
    assign hold    = (st == HOLD);
    assign apply   = ~bus.stall & (hold | bus.branch_taken | bus.jump);
    assign raw_tgt = bus.branch_taken ? bus.branch_target : hold ? pend_target : bus.jump_target;
    assign mis     = (bus.branch_taken & |bus.branch_target[1:0]) | (jump_acc & |bus.jump_target[1:0]);
    // a stall with any redirect in flight parks it in HOLD until the stall drops
    always_comb begin
        st_nxt = (bus.stall && (hold || bus.branch_taken || bus.jump)) ? HOLD : RUN;
    end
    // PC, flush, counter and sticky error update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            st      <= st_nxt;
            pc_q    <= apply ? {raw_tgt[WIDTH-1:2], 2'b00} : bus.stall ? pc_q : pc_q + WIDTH'(INC);
            flush_q <= apply;
            err_q   <= err_q | mis;
            cnt_q   <= cnt_q + CNT_W'(apply & ~&cnt_q);
        end
    end
    assign bus.pc             = pc_q;
    assign bus.pc_plus_inc    = pc_q + WIDTH'(INC);
    assign bus.flush          = flush_q;
    assign bus.pending        = hold;
    assign bus.misalign_err   = err_q;
    assign bus.redirect_count = cnt_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed table plus randomized run against a reference model
module tb_pc_redirect_unit;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pc_redirect_unit_if #(.WIDTH(32), .CNT_W(CW)) bus ();
    pc_redirect_unit #(.WIDTH(32), .RESET_PC(32'h0), .INC(4), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    int tests = 0;
    int fails = 0;
    logic [31:0] m_pc, m_tgt;
    bit m_flush, m_pend, m_isbr, m_err;
    int m_cnt;
    typedef struct {
        bit s; bit bt; logic [31:0] br; bit j; logic [31:0] jt;
        logic [31:0] pc; bit f; bit p; bit e; int c;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] al(logic [31:0] t);
        return t & ~32'h3;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_tgt = 0; m_flush = 0; m_pend = 0; m_isbr = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic m_redirect(logic [31:0] t);
        m_pc = al(t);
        m_flush = 1;
        if (m_cnt < CMAX) m_cnt++;
    endtask

    task automatic model_step(bit s, bit bt, logic [31:0] br, bit j, logic [31:0] jt);
        m_flush = 0;
        if (bt && br[1:0] != 0) m_err = 1;
        if (!m_pend) begin
            if (!s) begin
                if (bt) m_redirect(br);
                else if (j) begin
                    m_redirect(jt);
                    if (jt[1:0] != 0) m_err = 1;
                end else m_pc = m_pc + 4;
            end else if (bt || j) begin
                m_pend = 1;
                m_isbr = bt;
                m_tgt = bt ? al(br) : al(jt);
                if (!bt && jt[1:0] != 0) m_err = 1;
            end
        end else if (s) begin
            if (bt) begin
                m_isbr = 1;
                m_tgt = al(br);
            end else if (j && !m_isbr) begin
                m_tgt = al(jt);
                if (jt[1:0] != 0) m_err = 1;
            end
        end else begin
            m_redirect(bt ? br : m_tgt);
            m_pend = 0;
        end
    endtask

    task automatic step(bit s, bit bt, logic [31:0] br, bit j, logic [31:0] jt);
        bus.stall = s; bus.branch_taken = bt; bus.branch_target = br;
        bus.jump = j; bus.jump_target = jt;
        @(posedge clk);
        model_step(s, bt, br, j, jt);
        #1;
    endtask

    task automatic chk_model(int n);
        chk($sformatf("rnd%0d pc", n), bus.pc, m_pc);
        chk($sformatf("rnd%0d pc_plus_inc", n), bus.pc_plus_inc, m_pc + 4);
        chk($sformatf("rnd%0d flush", n), 32'(bus.flush), 32'(m_flush));
        chk($sformatf("rnd%0d pending", n), 32'(bus.pending), 32'(m_pend));
        chk($sformatf("rnd%0d misalign", n), 32'(bus.misalign_err), 32'(m_err));
        chk($sformatf("rnd%0d count", n), 32'(bus.redirect_count), 32'(m_cnt));
    endtask

    task automatic async_reset(string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, " pc"}, bus.pc, 32'h0);
        chk({tag, " pending"}, 32'(bus.pending), 32'h0);
        chk({tag, " flush"}, 32'(bus.flush), 32'h0);
        chk({tag, " misalign"}, 32'(bus.misalign_err), 32'h0);
        chk({tag, " count"}, 32'(bus.redirect_count), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        bus.jump = 0; bus.jump_target = 0;
        model_reset();
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h4,   0, 0, 0, 0});
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h8,   0, 0, 0, 0});
        tbl.push_back('{0, 1, 32'h100, 1, 32'h200, 32'h100, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h104, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 32'h0,   1, 32'h40,  32'h104, 0, 1, 0, 1});
        tbl.push_back('{1, 1, 32'h80,  0, 32'h0,   32'h104, 0, 1, 0, 1});
        tbl.push_back('{1, 0, 32'h0,   1, 32'h90,  32'h104, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h80,  1, 0, 0, 2});
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h84,  0, 0, 0, 2});
        tbl.push_back('{0, 1, 32'h103, 0, 32'h0,   32'h100, 1, 0, 1, 3});
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h104, 0, 0, 1, 3});
        tbl.push_back('{1, 0, 32'h0,   1, 32'h200, 32'h104, 0, 1, 1, 3});
        tbl.push_back('{1, 0, 32'h0,   1, 32'h300, 32'h104, 0, 1, 1, 3});
        tbl.push_back('{0, 0, 32'h0,   1, 32'h400, 32'h300, 1, 0, 1, 4});
        tbl.push_back('{0, 1, 32'h500, 1, 32'h600, 32'h500, 1, 0, 1, 5});
        tbl.push_back('{0, 0, 32'h0,   1, 32'h600, 32'h600, 1, 0, 1, 6});
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h604, 0, 0, 1, 6});
        tbl.push_back('{1, 0, 32'h0,   1, 32'h700, 32'h604, 0, 1, 1, 6});
        tbl.push_back('{0, 1, 32'h800, 0, 32'h0,   32'h800, 1, 0, 1, 7});
        tbl.push_back('{0, 0, 32'h0,   1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 1, 8});
        tbl.push_back('{0, 0, 32'h0,   0, 32'h0,   32'h0,   0, 0, 1, 8});
        tbl.push_back('{1, 0, 32'h0,   1, 32'h40,  32'h0,   0, 1, 1, 8});
        #1;
        chk("reset pc", bus.pc, 32'h0);
        chk("reset flush", 32'(bus.flush), 32'h0);
        chk("reset pending", 32'(bus.pending), 32'h0);
        chk("reset misalign", 32'(bus.misalign_err), 32'h0);
        chk("reset count", 32'(bus.redirect_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].bt, tbl[i].br, tbl[i].j, tbl[i].jt);
            chk($sformatf("v%0d pc", i), bus.pc, tbl[i].pc);
            chk($sformatf("v%0d pc_plus_inc", i), bus.pc_plus_inc, tbl[i].pc + 32'h4);
            chk($sformatf("v%0d flush", i), 32'(bus.flush), 32'(tbl[i].f));
            chk($sformatf("v%0d pending", i), 32'(bus.pending), 32'(tbl[i].p));
            chk($sformatf("v%0d misalign", i), 32'(bus.misalign_err), 32'(tbl[i].e));
            chk($sformatf("v%0d count", i), 32'(bus.redirect_count), 32'(tbl[i].c));
        end
        async_reset("hold_reset");
        step(0, 0, 32'h0, 0, 32'h0);
        chk("post_reset pc", bus.pc, 32'h4);
        chk("post_reset flush", 32'(bus.flush), 32'h0);
        chk("post_reset pending", 32'(bus.pending), 32'h0);
        for (int n = 0; n < 900; n++) begin
            logic [31:0] br, jt;
            bit s, bt, j;
            if (n % 300 == 299) async_reset($sformatf("rnd_reset%0d", n));
            s  = ($urandom_range(0, 9) < 4);
            bt = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 2) == 0);
            br = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 15) != 0) br[1:0] = 2'b00;
            if ($urandom_range(0, 15) != 0) jt[1:0] = 2'b00;
            step(s, bt, br, j, jt);
            chk_model(n);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
